// File: rtl/recorder_pkg.sv
// Shared types and default sizing for the audio recorder datapath
// (hold timer, record/playback sequencer, DAC stage).
package recorder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } rec_state_t;

  // 100 MHz / 2500 = 40 kHz sample rate; 128000 samples = 3.2 s of audio.
  localparam int unsigned DefaultDataW     = 8;
  localparam int unsigned DefaultAddrW     = 17;
  localparam int unsigned DefaultDepth     = 128000;
  localparam int unsigned DefaultSampleDiv = 2500;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider; tick is high on the last count of each period.
// A synchronous clear restarts the period so the first tick lands SAMPLE_DIV cycles later.
module sample_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 2500
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_DIV - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntOne;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/record_playback_ctrl.sv
// Record/playback sequencer: writes ADC samples into BRAM at the sample rate while recording,
// and replays the stored take to the DAC stage at the same rate.
module record_playback_ctrl
  import recorder_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned ADDR_W     = DefaultAddrW,
  parameter int unsigned DEPTH      = DefaultDepth,
  parameter int unsigned SAMPLE_DIV = DefaultSampleDiv
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              confirmed,
  input  logic              rec_req,
  input  logic              play_req,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] pcm_out,
  output logic              pcm_valid,
  output logic              recording,
  output logic              playing,
  output logic [ADDR_W:0]   rec_len
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);

  rec_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] pcm_q, pcm_d;
  logic              valid_q, valid_d;
  logic              we;
  logic              clear;
  logic              tick;

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    pcm_d   = pcm_q;
    valid_d = 1'b0;
    we      = 1'b0;
    clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Record takes priority when both requests are accepted together.
        if (rec_req && confirmed) begin
          state_d = RECORD;
          addr_d  = '0;
          len_d   = '0;
          clear   = 1'b1;
        end else if (play_req && (len_q != '0)) begin
          state_d = PLAY;
          addr_d  = '0;
          clear   = 1'b1;
        end
      end

      RECORD: begin
        if (tick) begin
          we    = 1'b1;
          len_d = {1'b0, addr_q} + LenOne;
          if (addr_q == LastAddr) begin
            state_d = IDLE;
          end else begin
            addr_d = addr_q + AddrOne;
          end
        end
        if (rec_req) begin
          state_d = IDLE;
        end
      end

      PLAY: begin
        // Address has been stable since the previous tick, so read data is already valid.
        if (tick) begin
          pcm_d   = mem_rdata;
          valid_d = 1'b1;
          if ({1'b0, addr_q} == (len_q - LenOne)) begin
            state_d = IDLE;
          end else begin
            addr_d = addr_q + AddrOne;
          end
        end
        if (play_req) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      pcm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      pcm_q   <= pcm_d;
      valid_q <= valid_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we;
  assign mem_wdata = we ? adc_data : '0;
  assign pcm_out   = pcm_q;
  assign pcm_valid = valid_q;
  assign recording = (state_q == RECORD);
  assign playing   = (state_q == PLAY);
  assign rec_len   = len_q;

endmodule
